demux_buffered: RTL and testbench

Buffered 1-to-N word demultiplexer: the distribution-side counterpart of the 2-input word mux. It accepts one WIDTH-bit word per cycle on a valid/ready input, along with a destination address, and delivers it to one of NOUT output ports. Each output port has a one-entry holding register with its own valid/ready handshake. It sits between a single producer (datapath result bus) and multiple independent consumers (register-file write ports, memory-mapped sinks). Out-of-range addresses are consumed, dropped and counted.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot.sv | 50 +++++
 rtl/demux_buffered.sv | 89 ++++++++
 tb/tb_demux_buffered.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module : demux_pkg
// Brief  : Shared defaults and slot state encoding for demux_buffered.
// Rev    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_ERR_W = 8;

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module : demux_slot
// Brief  : One-entry valid/ready holding register for one demux output port.
// Rev    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load wins over a drain: the new word replaces the one leaving this cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if ((state_q == SLOT_FULL) && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/demux_buffered.sv
`default_nettype none
// ============================================================================
// Module : demux_buffered
// Brief  : Buffered 1-to-NOUT word demultiplexer with per-port holding slots
//          and a saturating counter of words dropped for a bad address.
// Rev    : 1.0 - initial release
// ============================================================================
module demux_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NOUT   = 2,
    parameter int ADDR_W = 1,
    parameter int ERR_W  = DEFAULT_ERR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [WIDTH-1:0]      in_data,
    output logic [NOUT-1:0]       out_valid,
    input  logic [NOUT-1:0]       out_ready,
    output logic [NOUT*WIDTH-1:0] out_data,
    output logic [ERR_W-1:0]      err_count,
    output logic                  err_flag
);

    localparam logic [ADDR_W:0] c_nout = (ADDR_W + 1)'(NOUT);

    logic            w_addr_ok;
    logic            w_drop;
    logic [NOUT-1:0] w_sel;
    logic [NOUT-1:0] w_slot_open;
    logic [NOUT-1:0] w_load;

    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_flag_q,  err_flag_d;

    always_comb begin
        w_addr_ok = ({1'b0, in_addr} < c_nout);
        for (int k = 0; k < NOUT; k++) begin
            w_sel[k] = w_addr_ok && (in_addr == ADDR_W'(k));
        end
    end

    // A slot can take a word if it is empty or being drained this same cycle.
    assign w_slot_open = ~out_valid | out_ready;
    assign in_ready    = !w_addr_ok || (|(w_sel & w_slot_open));
    assign w_load      = {NOUT{in_valid}} & w_sel & w_slot_open;
    assign w_drop      = in_valid & ~w_addr_ok;

    always_comb begin
        err_count_d = err_count_q;
        if (w_drop && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
        err_flag_d = err_flag_q | w_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign err_count = err_count_q;
    assign err_flag  = err_flag_q;

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_buffered.sv
`default_nettype none
// ============================================================================
// Module : tb_demux_buffered
// Brief  : Self-checking bench for demux_buffered (NOUT=3 with ERR_W 8 and 2,
//          plus default NOUT=2 under random valid/ready traffic).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_demux_buffered;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // DUT A (ERR_W=8) and DUT B (ERR_W=2) share the same stimulus
    logic        a_in_valid;
    logic [1:0]  a_in_addr;
    logic [31:0] a_in_data;
    logic [2:0]  a_out_ready;
    logic        a_in_ready,  b_in_ready;
    logic [2:0]  a_out_valid, b_out_valid;
    logic [95:0] a_out_data,  b_out_data;
    logic [7:0]  a_err_count;
    logic [1:0]  b_err_count;
    logic        a_err_flag,  b_err_flag;

    // DUT C: default parameters
    logic        c_in_valid;
    logic [0:0]  c_in_addr;
    logic [31:0] c_in_data;
    logic [1:0]  c_out_ready;
    logic        c_in_ready;
    logic [1:0]  c_out_valid;
    logic [63:0] c_out_data;
    logic [7:0]  c_err_count;
    logic        c_err_flag;

    demux_buffered #(.WIDTH(32), .NOUT(3), .ADDR_W(2), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .err_count(a_err_count),
        .err_flag(a_err_flag));

    demux_buffered #(.WIDTH(32), .NOUT(3), .ADDR_W(2), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(b_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .out_valid(b_out_valid),
        .out_ready(a_out_ready), .out_data(b_out_data), .err_count(b_err_count),
        .err_flag(b_err_flag));

    demux_buffered u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_addr(c_in_addr), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .err_count(c_err_count),
        .err_flag(c_err_flag));

    int total = 0;
    int bad   = 0;

    // Scoreboard: ports 0..2 belong to A/B, ports 3..4 to C (C port = index-3)
    int unsigned sb_port[$];
    logic [31:0] sb_data[$];
    int          err_a, err_b;
    logic        flag_a;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_remove(input int unsigned p);
        for (int i = 0; i < sb_port.size(); i++) begin
            if (sb_port[i] == p) begin
                sb_port.delete(i);
                sb_data.delete(i);
                break;
            end
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_a_valid", 96'(a_out_valid), 96'd0);
        chk("rst_a_data",  a_out_data,       96'd0);
        chk("rst_a_err",   96'(a_err_count), 96'd0);
        chk("rst_a_flag",  96'(a_err_flag),  96'd0);
        chk("rst_b_valid", 96'(b_out_valid), 96'd0);
        chk("rst_b_err",   96'(b_err_count), 96'd0);
        chk("rst_c_valid", 96'(c_out_valid), 96'd0);
        chk("rst_c_data",  96'(c_out_data),  96'd0);
    endtask

    // Inputs are already driven (at a negedge); check, clock once, update model.
    task automatic step();
        logic [2:0]  va;
        logic [1:0]  vc;
        logic [31:0] ed [5];
        logic        ra, rc;
        #1;
        va = '0;
        vc = '0;
        for (int k = 0; k < 5; k++) ed[k] = '0;
        for (int i = 0; i < sb_port.size(); i++) begin
            ed[sb_port[i]] = sb_data[i];
            if (sb_port[i] < 3) va[sb_port[i]] = 1'b1;
            else                vc[sb_port[i] - 3] = 1'b1;
        end
        ra = (a_in_addr < 2'd3) ? (!va[a_in_addr] || a_out_ready[a_in_addr]) : 1'b1;
        rc = !vc[c_in_addr] || c_out_ready[c_in_addr];

        chk("a_in_ready",  96'(a_in_ready),  96'(ra));
        chk("b_in_ready",  96'(b_in_ready),  96'(ra));
        chk("c_in_ready",  96'(c_in_ready),  96'(rc));
        chk("a_out_valid", 96'(a_out_valid), 96'(va));
        chk("b_out_valid", 96'(b_out_valid), 96'(va));
        chk("c_out_valid", 96'(c_out_valid), 96'(vc));
        for (int k = 0; k < 3; k++) begin
            if (va[k]) chk($sformatf("a_out_data%0d", k), 96'(a_out_data[k*32 +: 32]), 96'(ed[k]));
        end
        for (int k = 0; k < 2; k++) begin
            if (vc[k]) chk($sformatf("c_out_data%0d", k), 96'(c_out_data[k*32 +: 32]), 96'(ed[3+k]));
        end
        chk("a_err_count", 96'(a_err_count), 96'(err_a));
        chk("b_err_count", 96'(b_err_count), 96'(err_b));
        chk("a_err_flag",  96'(a_err_flag),  96'(flag_a));
        chk("b_err_flag",  96'(b_err_flag),  96'(flag_a));
        chk("c_err_count", 96'(c_err_count), 96'd0);
        chk("c_err_flag",  96'(c_err_flag),  96'd0);

        @(posedge clk);
        for (int k = 0; k < 3; k++) if (va[k] && a_out_ready[k]) sb_remove(k);
        for (int k = 0; k < 2; k++) if (vc[k] && c_out_ready[k]) sb_remove(3 + k);
        if (a_in_valid && ra) begin
            if (a_in_addr < 2'd3) begin
                sb_port.push_back(int'(a_in_addr));
                sb_data.push_back(a_in_data);
            end else begin
                if (err_a < 255) err_a++;
                if (err_b < 3)   err_b++;
                flag_a = 1'b1;
            end
        end
        if (c_in_valid && rc) begin
            sb_port.push_back(3 + int'(c_in_addr));
            sb_data.push_back(c_in_data);
        end
        @(negedge clk);
    endtask

    task automatic drive_a(input logic v, input logic [1:0] addr,
                           input logic [31:0] data, input logic [2:0] rdy);
        a_in_valid  = v;
        a_in_addr   = addr;
        a_in_data   = data;
        a_out_ready = rdy;
    endtask

    initial begin
        drive_a(1'b0, 2'd0, 32'h0, 3'b111);
        c_in_valid  = 1'b0;
        c_in_addr   = 1'b0;
        c_in_data   = 32'h0;
        c_out_ready = 2'b00;
        err_a  = 0;
        err_b  = 0;
        flag_a = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic routing, all consumers ready
        drive_a(1'b1, 2'd0, 32'h0000FFFF, 3'b111); step();
        drive_a(1'b1, 2'd1, 32'h000072C4, 3'b111); step();
        drive_a(1'b1, 2'd2, 32'h0000AAAA, 3'b111); step();
        drive_a(1'b0, 2'd0, 32'h0,        3'b111); step();
        step();

        // back-pressure on port 1 while port 0 keeps flowing
        drive_a(1'b1, 2'd1, 32'h00005555, 3'b101); step();
        drive_a(1'b1, 2'd1, 32'h0000AAAA, 3'b101); step();
        step();
        drive_a(1'b1, 2'd0, 32'h0000932B, 3'b101); step();
        drive_a(1'b0, 2'd0, 32'h0,        3'b101); step();
        drive_a(1'b1, 2'd1, 32'h0000AAAA, 3'b111); step();
        drive_a(1'b0, 2'd0, 32'h0,        3'b111); step();

        // same-cycle drain and refill of port 2
        drive_a(1'b1, 2'd2, 32'h0000AB32, 3'b011); step();
        drive_a(1'b1, 2'd2, 32'h00000DC2, 3'b111); step();
        drive_a(1'b0, 2'd0, 32'h0,        3'b011); step();
        chk("drain_refill_data", 96'(a_out_data[64 +: 32]), 96'h0DC2);
        drive_a(1'b0, 2'd0, 32'h0,        3'b111); step();

        // asynchronous reset with slots 0 and 2 full and a drop counted
        drive_a(1'b1, 2'd3, 32'h0000DEAD, 3'b000); step();
        drive_a(1'b1, 2'd0, 32'h00001111, 3'b000); step();
        drive_a(1'b1, 2'd2, 32'h00002222, 3'b000); step();
        drive_a(1'b0, 2'd0, 32'h0,        3'b000); step();
        rst_n = 1'b0;
        #1 chk_reset_state();
        sb_port.delete();
        sb_data.delete();
        err_a  = 0;
        err_b  = 0;
        flag_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // bad address drops; B saturates at 3
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 2'd3, 32'hBAD0_0000 + 32'(i), 3'b111);
            step();
        end
        drive_a(1'b0, 2'd0, 32'h0, 3'b111); step();
        chk("drop4_a_err",  96'(a_err_count), 96'd4);
        chk("drop4_b_err",  96'(b_err_count), 96'd3);
        chk("drop4_flag",   96'(a_err_flag),  96'd1);
        drive_a(1'b1, 2'd3, 32'hBAD0_0004, 3'b111); step();
        drive_a(1'b0, 2'd0, 32'h0,         3'b111); step();
        chk("drop5_a_err",  96'(a_err_count), 96'd5);
        chk("drop5_b_sat",  96'(b_err_count), 96'd3);
        step();

        // default-parameter instance under random traffic
        for (int i = 0; i < 1000; i++) begin
            c_in_valid  = 1'($urandom_range(0, 1));
            c_in_addr   = 1'($urandom_range(0, 1));
            c_in_data   = $urandom;
            c_out_ready = 2'($urandom_range(0, 3));
            step();
        end
        c_in_valid  = 1'b0;
        c_out_ready = 2'b11;
        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", 96'(sb_port.size()), 96'd0);
        chk("c_err_final", 96'(c_err_count), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
